// File: rtl/me_search_scheduler_if.sv
// me_search_scheduler_if: handshake bundle between ME pipeline control, SAD engine and scheduler.
// Parameters must match the scheduler instance they connect to.
interface me_search_scheduler_if #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48,
  parameter int SAD_W      = 16,
  parameter int MV_W       = 6
);
  localparam int NPOS = SEARCH_DIM - MACRO_DIM + 1;
  localparam int CW   = $clog2(NPOS);

  logic                   start;
  logic                   sad_valid;
  logic [SAD_W-1:0]       sad;
  logic [SAD_W-1:0]       early_thr;
  logic                   sad_start;
  logic [CW-1:0]          cand_x;
  logic [CW-1:0]          cand_y;
  logic                   busy;
  logic                   done;
  logic [SAD_W-1:0]       best_sad;
  logic signed [MV_W-1:0] best_mvx;
  logic signed [MV_W-1:0] best_mvy;

  modport master (
    output start, sad_valid, sad, early_thr,
    input  sad_start, cand_x, cand_y, busy, done, best_sad, best_mvx, best_mvy
  );

  modport slave (
    input  start, sad_valid, sad, early_thr,
    output sad_start, cand_x, cand_y, busy, done, best_sad, best_mvx, best_mvy
  );
endinterface

// File: rtl/me_search_scheduler.sv
// me_search_scheduler: raster full-search scheduler for integer ME, tracks min SAD and best MV.
// Optional early termination on SAD below early_thr when compiled with EARLY_TERM_EN.
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | launch current candidate (sad_start shows next cycle)
// WAIT   | waiting for sad_valid from the SAD engine
// UPDATE | strict-less min compare, advance raster position
// DONE   | publish best_* with a done pulse
module me_search_scheduler #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48,
  parameter int SAD_W      = 16,
  parameter int MV_W       = 6
) (
  input logic                  clk,
  input logic                  rst,
  me_search_scheduler_if.slave bus
);
  localparam int            NPOS = SEARCH_DIM - MACRO_DIM + 1;
  localparam int            CW   = $clog2(NPOS);
  localparam int            HALF = (NPOS - 1) / 2;
  localparam logic [CW-1:0] LAST = CW'(NPOS - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, UPDATE, DONE} state_t;

  state_t                 state;
  logic [CW-1:0]          cand_x;
  logic [CW-1:0]          cand_y;
  logic [CW-1:0]          best_x;
  logic [CW-1:0]          best_y;
  logic [SAD_W-1:0]       min_sad;
  logic [SAD_W-1:0]       sad_q;
  logic [SAD_W-1:0]       best_sad;
  logic signed [MV_W-1:0] best_mvx;
  logic signed [MV_W-1:0] best_mvy;
  logic                   sad_start;
  logic                   busy;
  logic                   done;
  logic                   better;
  logic                   last_cand;
  logic                   stop_early;

  assign better    = sad_q < min_sad;
  assign last_cand = (cand_x == LAST) && (cand_y == LAST);

`ifdef EARLY_TERM_EN
  // early_thr = 0 can never be undercut, so it disables early exit naturally
  assign stop_early = sad_q < bus.early_thr;
`else
  logic unused_early_thr;
  assign unused_early_thr = ^bus.early_thr;
  assign stop_early       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cand_x    <= '0;
      cand_y    <= '0;
      best_x    <= '0;
      best_y    <= '0;
      min_sad   <= '0;
      sad_q     <= '0;
      best_sad  <= '0;
      best_mvx  <= '0;
      best_mvy  <= '0;
      sad_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      sad_start <= 1'b0;
      done      <= 1'b0;
      if (done) busy <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            cand_x  <= '0;
            cand_y  <= '0;
            best_x  <= '0;
            best_y  <= '0;
            min_sad <= '1;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          sad_start <= 1'b1;
          state     <= WAIT;
        end
        WAIT: begin
          if (bus.sad_valid) begin
            sad_q <= bus.sad;
            state <= UPDATE;
          end
        end
        UPDATE: begin
          if (better) begin
            min_sad <= sad_q;
            best_x  <= cand_x;
            best_y  <= cand_y;
          end
          // hold the final position so cand never leaves 0..NPOS-1
          if (!last_cand) begin
            if (cand_x == LAST) begin
              cand_x <= '0;
              cand_y <= cand_y + 1'b1;
            end else begin
              cand_x <= cand_x + 1'b1;
            end
          end
          state <= (last_cand || stop_early) ? DONE : ISSUE;
        end
        DONE: begin
          done     <= 1'b1;
          best_sad <= min_sad;
          best_mvx <= MV_W'(best_x) - MV_W'(HALF);
          best_mvy <= MV_W'(best_y) - MV_W'(HALF);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sad_start = sad_start;
  assign bus.cand_x    = cand_x;
  assign bus.cand_y    = cand_y;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.best_sad  = best_sad;
  assign bus.best_mvx  = best_mvx;
  assign bus.best_mvy  = best_mvy;
endmodule

// File: tb/tb_me_search_scheduler.sv
// tb_me_search_scheduler: table-driven searches against a raster-order reference model,
// plus hand-written reset, small-window timing and protocol sequences.
module tb_me_search_scheduler;
  localparam int NP0 = 33;
  localparam int NP1 = 5;
  localparam int M_ABS = 0, M_CONST = 1, M_EARLY = 2, M_RAND = 3;

  typedef struct {
    string name;
    int    mode;
    int    lat;
    int    inject;
    int    thr;
    int    exp_n;
    int    exp_sad;
    int    exp_mvx;
    int    exp_mvy;
    int    use_model;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  me_search_scheduler_if bus0 ();
  me_search_scheduler_if #(.MACRO_DIM(4), .SEARCH_DIM(8)) bus1 ();

  me_search_scheduler u0 (.clk(clk), .rst(rst), .bus(bus0));
  me_search_scheduler #(.MACRO_DIM(4), .SEARCH_DIM(8)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  logic start_req0 = 1'b0, start_inj0 = 1'b0, start_req1 = 1'b0;
  assign bus0.start = start_req0 | start_inj0;
  assign bus1.start = start_req1;

  int n_pass = 0, n_tot = 0;
  int sad_tab[NP0*NP0];
  int lat0 = 0, inject0 = 0;
  int n_start0 = 0, n_done0 = 0, order_err0 = 0, busy_err0 = 0, exp_idx0 = 0;
  int pend0 = -1, post0 = 0, cur_x0 = 0, cur_y0 = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void fill_tab(input int mode, input int np);
    for (int i = 0; i < np*np; i++) begin
      case (mode)
        M_ABS:   sad_tab[i] = iabs(i % np - 20) + iabs(i / np - 9);
        M_CONST: sad_tab[i] = 100;
        M_EARLY: sad_tab[i] = (i == 3) ? 40 : 200;
        default: sad_tab[i] = int'($urandom_range(0, 400));
      endcase
    end
  endfunction

  // reference: first raster index holding the minimum; optional stop at first sad below thr
  function automatic void model(input int np, input int thr, output int n, output int bs,
                                output int mvx, output int mvy);
    int bi;
    bs = 65535; bi = 0; n = np*np;
    for (int i = 0; i < np*np; i++) begin
      if (sad_tab[i] < bs) begin bs = sad_tab[i]; bi = i; end
`ifdef EARLY_TERM_EN
      if (sad_tab[i] < thr) begin n = i + 1; break; end
`endif
    end
    mvx = bi % np - (np - 1) / 2;
    mvy = bi / np - (np - 1) / 2;
  endfunction

  // SAD engine + monitor for the default-size instance
  initial begin
    bus0.sad_valid = 1'b0;
    bus0.sad       = '0;
    bus0.early_thr = '0;
    forever begin
      @(negedge clk);
      bus0.sad_valid = 1'b0;
      start_inj0     = 1'b0;
      if (post0 > 0) begin
        post0--;
        if (inject0 != 0) begin bus0.sad_valid = 1'b1; bus0.sad = '0; end
      end
      if (bus0.sad_start) begin
        n_start0++;
        if (int'(bus0.cand_x) != exp_idx0 % NP0 || int'(bus0.cand_y) != exp_idx0 / NP0) order_err0++;
        exp_idx0++;
        cur_x0 = int'(bus0.cand_x);
        cur_y0 = int'(bus0.cand_y);
        pend0  = lat0;
        if (inject0 != 0) start_inj0 = 1'b1;
      end
      if (pend0 == 0) begin
        bus0.sad_valid = 1'b1;
        bus0.sad       = 16'(sad_tab[cur_y0*NP0 + cur_x0]);
        pend0 = -1;
        post0 = 2;
      end else if (pend0 > 0) begin
        pend0--;
      end
      if (bus0.done) begin
        n_done0++;
        if (!bus0.busy) busy_err0++;
      end
    end
  end

  task automatic clear_mon0();
    n_start0 = 0; n_done0 = 0; order_err0 = 0; busy_err0 = 0; exp_idx0 = 0;
  endtask

  task automatic pulse_start0();
    @(negedge clk) start_req0 = 1'b1;
    @(negedge clk) start_req0 = 1'b0;
  endtask

  task automatic run_search(input vec_t v);
    int n, bs, mx, my, budget;
    fill_tab(v.mode, NP0);
    if (v.use_model != 0) begin
      model(NP0, v.thr, n, bs, mx, my);
      v.exp_n = n; v.exp_sad = bs; v.exp_mvx = mx; v.exp_mvy = my;
    end
    lat0 = v.lat;
    inject0 = v.inject;
    bus0.early_thr = 16'(v.thr);
    clear_mon0();
    pulse_start0();
    check({v.name, "_busy_after_start"}, bus0.busy, 1);
    budget = 0;
    while (n_done0 == 0 && budget < 40000) begin @(negedge clk); budget++; end
    check({v.name, "_done_seen"}, (n_done0 > 0) ? 1 : 0, 1);
    repeat (6) @(negedge clk);
    check({v.name, "_pulses"}, n_start0, v.exp_n);
    check({v.name, "_best_sad"}, bus0.best_sad, v.exp_sad);
    check({v.name, "_best_mvx"}, int'(bus0.best_mvx), v.exp_mvx);
    check({v.name, "_best_mvy"}, int'(bus0.best_mvy), v.exp_mvy);
    check({v.name, "_done_count"}, n_done0, 1);
    check({v.name, "_raster_order"}, order_err0, 0);
    check({v.name, "_busy_at_done"}, busy_err0, 0);
    check({v.name, "_busy_cleared"}, bus0.busy, 0);
    inject0 = 0;
  endtask

  vec_t tbl[6];

  initial begin
    int n, bs, mx, my, b, c0, n1;
    int xs[NP1*NP1];
    int ys[NP1*NP1];

    tbl[0] = '{"full_abs",  M_ABS,   22, 0, 0,  1089, 0,   4,   -7,  0};
    tbl[1] = '{"ties",      M_CONST, 0,  0, 0,  1089, 100, -16, -16, 0};
    tbl[2] = '{"protocol",  M_ABS,   1,  1, 0,  1089, 0,   4,   -7,  0};
`ifdef EARLY_TERM_EN
    tbl[3] = '{"early",     M_EARLY, 0,  0, 50, 4,    40,  -13, -16, 0};
    tbl[4] = '{"rand_a",    M_RAND,  int'($urandom_range(0, 2)), 0, int'($urandom_range(0, 60)), 0, 0, 0, 0, 1};
    tbl[5] = '{"rand_b",    M_RAND,  int'($urandom_range(0, 2)), 0, int'($urandom_range(0, 60)), 0, 0, 0, 0, 1};
`else
    tbl[3] = '{"early_off", M_EARLY, 0,  0, 50, 1089, 40,  -13, -16, 0};
    tbl[4] = '{"rand_a",    M_RAND,  int'($urandom_range(0, 2)), 0, 0, 0, 0, 0, 0, 1};
    tbl[5] = '{"rand_b",    M_RAND,  int'($urandom_range(0, 2)), 0, 0, 0, 0, 0, 0, 1};
`endif
    bus1.sad_valid = 1'b0;
    bus1.sad       = '0;
    bus1.early_thr = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy0", bus0.busy, 0);
    check("rst_sad_start0", bus0.sad_start, 0);
    check("rst_best_sad0", bus0.best_sad, 0);
    check("rst_done1", bus1.done, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_search(tbl[i]);

    // small window: 25 candidates, engine answers one cycle after sad_start
    for (int i = 0; i < NP1*NP1; i++) sad_tab[i] = (i*7 + 3) % 13 + 5;
    model(NP1, 0, n, bs, mx, my);
    n1 = 0;
    @(negedge clk) begin start_req1 = 1'b1; c0 = cyc; end
    @(negedge clk) start_req1 = 1'b0;
    check("small_busy_after_start", bus1.busy, 1);
    for (int i = 0; i < NP1*NP1; i++) begin
      b = 0;
      while (!bus1.sad_start && b < 20) begin @(negedge clk); b++; end
      if (!bus1.sad_start) begin
        check("small_sad_start_seen", 0, 1);
        break;
      end
      xs[i] = int'(bus1.cand_x);
      ys[i] = int'(bus1.cand_y);
      n1++;
      @(negedge clk) begin bus1.sad_valid = 1'b1; bus1.sad = 16'(sad_tab[i]); end
      @(negedge clk) bus1.sad_valid = 1'b0;
    end
    b = 0;
    while (!bus1.done && b < 20) begin @(negedge clk); b++; end
    check("small_done_latency", cyc - c0, 1 + 25*4 + 1);
    check("small_busy_at_done", bus1.busy, 1);
    check("small_pulses", n1, 25);
    check("small_wrap_x4", xs[4]*10 + ys[4], 40);
    check("small_wrap_x5", xs[5]*10 + ys[5], 1);
    check("small_last", xs[24]*10 + ys[24], 44);
    check("small_best_sad", bus1.best_sad, bs);
    check("small_best_mvx", int'(bus1.best_mvx), mx);
    check("small_best_mvy", int'(bus1.best_mvy), my);
    @(negedge clk);
    check("small_busy_cleared", bus1.busy, 0);
    check("small_done_single", bus1.done, 0);

    // reset in the middle of WAIT
    fill_tab(M_ABS, NP0);
    lat0 = 22;
    clear_mon0();
    pulse_start0();
    b = 0;
    while (n_start0 == 0 && b < 100) begin @(negedge clk); b++; end
    check("midrst_first_pulse", n_start0, 1);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("midrst_sad_start", bus0.sad_start, 0);
    check("midrst_cand_x", bus0.cand_x, 0);
    check("midrst_cand_y", bus0.cand_y, 0);
    check("midrst_busy", bus0.busy, 0);
    check("midrst_done", bus0.done, 0);
    check("midrst_best_sad", bus0.best_sad, 0);
    check("midrst_best_mvx", int'(bus0.best_mvx), 0);
    check("midrst_best_mvy", int'(bus0.best_mvy), 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("midrst_idle_no_pulse", bus0.sad_start, 0);
    run_search(tbl[1]);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
